// File: rtl/bnn_output_collector.sv
// +---------------------------------------------------------------------------+
// | bnn_output_collector                                                      |
// | Packs a 1-bit neuron decision stream LSB-first into bytes for the host,  |
// | with a per-frame popcount and a thresholded frame decision.              |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module bnn_output_collector #(
  parameter int FRAME_LEN = 16,
  parameter int THRESH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       frame_start,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic [7:0] popcount,
  output logic       decision,
  output logic       overflow
);

  localparam logic [7:0] c_last_cnt = 8'(FRAME_LEN - 1);
  localparam logic [7:0] c_thresh   = 8'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_asm;
  logic [2:0] r_bit_idx;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_popcount;
  logic [7:0] r_out_data;
  logic       r_out_valid;
  logic       r_decision;
  logic       r_overflow;

  logic       w_take;
  logic       w_byte_done;
  logic       w_last;
  logic       w_load;
  logic [7:0] w_asm_next;
  logic [7:0] w_pop_next;

  // A restart wins over a bit arriving in the same cycle.
  assign w_take      = (r_state == S_COLLECT) & bit_valid & ~frame_start;
  assign w_byte_done = w_take & (r_bit_idx == 3'd7);
  assign w_last      = w_take & (r_frame_cnt == c_last_cnt);
  assign w_load      = w_byte_done & (~r_out_valid | out_ready);
  assign w_pop_next  = r_popcount + {7'd0, bit_in};

  always_comb begin
    w_asm_next            = r_asm;
    w_asm_next[r_bit_idx] = bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (frame_start) begin
      w_state_next = S_COLLECT;
    end else begin
      case (r_state)
        S_IDLE:    w_state_next = S_IDLE;
        S_COLLECT: if (w_last) w_state_next = S_DONE;
        S_DONE:    w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm       <= 8'h00;
      r_bit_idx   <= 3'd0;
      r_frame_cnt <= 8'd0;
      r_popcount  <= 8'd0;
      r_decision  <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (frame_start) begin
      r_asm       <= 8'h00;
      r_bit_idx   <= 3'd0;
      r_frame_cnt <= 8'd0;
      r_popcount  <= 8'd0;
      r_overflow  <= 1'b0;
    end else if (w_take) begin
      r_asm       <= w_byte_done ? 8'h00 : w_asm_next;
      r_bit_idx   <= r_bit_idx + 3'd1;
      r_frame_cnt <= r_frame_cnt + 8'd1;
      r_popcount  <= w_pop_next;
      // Decision only ever sees the popcount of a complete frame.
      if (w_last) begin
        r_decision <= (w_pop_next >= c_thresh);
      end
      if (w_byte_done && !w_load) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Pending byte survives a restart; it is only replaced once accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_asm_next;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign frame_done = (r_state == S_DONE);
  assign popcount   = r_popcount;
  assign decision   = r_decision;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bnn_output_collector.sv
// +---------------------------------------------------------------------------+
// | tb_bnn_output_collector                                                   |
// | Directed self-checking bench for bnn_output_collector (16-bit frame).    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_bnn_output_collector;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       frame_start;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic [7:0] popcount;
  logic       decision;
  logic       overflow;

  int         n_tests;
  int         n_fail;
  int         fd_cnt;
  int         fd_base;
  logic [7:0] byte_q[$];

  bnn_output_collector #(
    .FRAME_LEN(16),
    .THRESH   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .popcount   (popcount),
    .decision   (decision),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted bytes and frame_done pulses as the host would see them.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) byte_q.push_back(out_data);
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] bits);
    for (int i = 0; i < 16; i++) send_bit(bits[i]);
  endtask

  initial begin
    logic [15:0] v;
    n_tests = 0; n_fail = 0; fd_cnt = 0;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;

    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_popcount", 32'(popcount), 0);
    check("rst_decision", 32'(decision), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_frame_done", 32'(frame_done), 0);

    // Bits offered while idle must be ignored.
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom_range(0, 1));
      step();
      check("idle_no_out", 32'(out_valid), 0);
      check("idle_popcount", 32'(popcount), 0);
    end
    bit_valid = 1'b0;

    // Frame 1: bits 1,0,1,1,0,0,0,0, 1x8 -> 0x0D, 0xFF.
    byte_q.delete();
    fd_base = fd_cnt;
    start_frame();
    v = 16'hFF0D;
    for (int i = 0; i < 16; i++) begin
      send_bit(v[i]);
      if (i == 7) begin
        check("f1_b0_valid", 32'(out_valid), 1);
        check("f1_b0_data", 32'(out_data), 32'h0D);
        check("f1_b0_no_done", 32'(frame_done), 0);
      end
    end
    check("f1_done", 32'(frame_done), 1);
    check("f1_b1_valid", 32'(out_valid), 1);
    check("f1_b1_data", 32'(out_data), 32'hFF);
    check("f1_popcount", 32'(popcount), 11);
    check("f1_decision", 32'(decision), 1);
    step();
    check("f1_done_pulse", 32'(frame_done), 0);
    check("f1_fd_count", 32'(fd_cnt - fd_base), 1);
    check("f1_nbytes", 32'(byte_q.size()), 2);
    if (byte_q.size() == 2) begin
      check("f1_q0", 32'(byte_q[0]), 32'h0D);
      check("f1_q1", 32'(byte_q[1]), 32'hFF);
    end

    // Threshold boundary: 7 ones then exactly 8 ones.
    start_frame();
    check("th_restart_pop", 32'(popcount), 0);
    check("th_decision_held", 32'(decision), 1);
    send_frame(16'h007F);
    check("th7_popcount", 32'(popcount), 7);
    check("th7_decision", 32'(decision), 0);
    start_frame();
    send_frame(16'h00FF);
    check("th8_popcount", 32'(popcount), 8);
    check("th8_decision", 32'(decision), 1);
    step(); step();

    // Backpressure for a whole frame: second byte dropped.
    byte_q.delete();
    out_ready = 1'b0;
    start_frame();
    send_frame(16'h005A);
    check("bp_mid_valid", 32'(out_valid), 1);
    check("bp_mid_data", 32'(out_data), 32'h5A);
    check("bp_end_valid", 32'(out_valid), 1);
    check("bp_end_data", 32'(out_data), 32'h5A);
    check("bp_overflow", 32'(overflow), 1);
    out_ready = 1'b1;
    step();
    check("bp_valid_fall", 32'(out_valid), 0);
    check("bp_nbytes", 32'(byte_q.size()), 1);
    if (byte_q.size() == 1) check("bp_q0", 32'(byte_q[0]), 32'h5A);
    check("bp_overflow_sticky", 32'(overflow), 1);

    // Accept and reload on the same edge.
    byte_q.delete();
    out_ready = 1'b0;
    start_frame();
    check("ar_overflow_clr", 32'(overflow), 0);
    v = 16'h3CC3;
    for (int i = 0; i < 15; i++) send_bit(v[i]);
    check("ar_hold_valid", 32'(out_valid), 1);
    check("ar_hold_data", 32'(out_data), 32'hC3);
    out_ready = 1'b1;
    send_bit(v[15]);
    check("ar_valid", 32'(out_valid), 1);
    check("ar_data", 32'(out_data), 32'h3C);
    check("ar_overflow", 32'(overflow), 0);
    step();
    check("ar_nbytes", 32'(byte_q.size()), 2);
    if (byte_q.size() == 2) begin
      check("ar_q0", 32'(byte_q[0]), 32'hC3);
      check("ar_q1", 32'(byte_q[1]), 32'h3C);
    end

    // Mid-frame restart with a coincident bit.
    byte_q.delete();
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    frame_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    frame_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check("mr_popcount", 32'(popcount), 0);
    check("mr_no_out", 32'(out_valid), 0);
    fd_base = fd_cnt;
    send_frame(16'h0FF0);
    check("mr_done", 32'(frame_done), 1);
    check("mr_popcount_end", 32'(popcount), 8);
    step();
    check("mr_fd_count", 32'(fd_cnt - fd_base), 1);
    check("mr_nbytes", 32'(byte_q.size()), 2);
    if (byte_q.size() == 2) begin
      check("mr_q0", 32'(byte_q[0]), 32'hF0);
      check("mr_q1", 32'(byte_q[1]), 32'h0F);
    end

    // Reset mid-frame with a pending byte.
    out_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    check("rm_pending", 32'(out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rm_out_valid", 32'(out_valid), 0);
    check("rm_out_data", 32'(out_data), 0);
    check("rm_popcount", 32'(popcount), 0);
    check("rm_decision", 32'(decision), 0);
    check("rm_overflow", 32'(overflow), 0);
    check("rm_frame_done", 32'(frame_done), 0);
    fd_base = fd_cnt;
    send_frame(16'hFFFF);
    step();
    check("rm_idle_no_done", 32'(fd_cnt - fd_base), 0);
    check("rm_idle_no_out", 32'(out_valid), 0);
    out_ready = 1'b1;
    start_frame();
    send_frame(16'hFFFF);
    check("rm_new_done", 32'(frame_done), 1);
    check("rm_new_popcount", 32'(popcount), 16);
    step();
    check("rm_fd_count", 32'(fd_cnt - fd_base), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bnn_output_collector.md
# bnn_output_collector

Consumer end of the BNN neuron's 1-bit `o_neuron` result stream. Accepts one neuron decision per strobe over a frame of evaluations, packs decisions LSB-first into bytes, and hands each byte to the host over a valid/ready handshake. Keeps a per-frame popcount and produces a thresholded frame decision. Sits between the neuron output and the chip's output pins / readout logic.

## Interface

Parameters:
- `FRAME_LEN`, 16: neuron decisions per frame. Must be a multiple of 8, range 8..248.
- `THRESH`, 8: frame decision is 1 when popcount >= THRESH. Range 0..FRAME_LEN.

Ports:
- `clk`  in  1  Single clock. All state updates on its rising edge.
- `rst`  in  1  Reset. Synchronous, active-high.
- `bit_in`  in  1  Neuron decision (`o_neuron`).
- `bit_valid`  in  1  `bit_in` is sampled on this edge. Ignored outside COLLECT.
- `frame_start`  in  1  Synchronous frame (re)start.
- `out_data`  out  8  Packed byte. Bit k is the k-th decision of that byte.
- `out_valid`  out  1  `out_data` is valid. Held until accepted.
- `out_ready`  in  1  Host accepts `out_data` on an edge where `out_valid & out_ready`.
- `frame_done`  out  1  One-cycle pulse when the frame completes.
- `popcount`  out  8  Number of 1s in the current or last frame.
- `decision`  out  1  `popcount >= THRESH`, registered at frame end.
- `overflow`  out  1  Sticky. Set when a completed byte was dropped.

## Operation

- FSM states:
  - IDLE:
    - `frame_start` moves to COLLECT.
    - `bit_valid` is ignored.
  - COLLECT:
    - Each `bit_valid` shifts `bit_in` into the assembly register at position `bit_idx`.
    - Increments `bit_idx` (3 bits, wraps 7→0) and `frame_cnt`.
    - Adds `bit_in` to `popcount`.
    - Moves to DONE on the edge accepting bit number FRAME_LEN.
  - DONE:
    - Asserts `frame_done` for exactly one cycle.
    - Then moves to IDLE, unless `frame_start` is high in that cycle, in which case it moves to COLLECT.
- Byte completion: on the edge that accepts a byte's 8th bit, the full byte (including that bit) goes to the output register.
  - The byte loads if `out_valid` is 0, or if `out_valid & out_ready` in the same cycle (accept and reload; `out_valid` stays 1).
  - Otherwise the byte is dropped, `overflow` is set, and the pending `out_data` is unchanged.
- `out_valid` clears on accept when no new byte loads in the same edge.
- `frame_start` in any state:
  - Clears the assembly register, `bit_idx`, `frame_cnt`, `popcount`, and `overflow`.
  - Enters COLLECT.
  - A `bit_valid` in the same cycle is ignored.
  - A pending output byte and its `out_valid` are preserved.
  - `decision` keeps its last value.
- `frame_start` mid-frame discards the partial byte. No partial byte is ever emitted.
- `decision` is loaded on the DONE-entry edge from the final popcount, so it is never computed from a truncated frame.
- `decision` and `popcount` hold until the next `frame_start`.
- Widths:
  - `popcount` is 8 bits and cannot overflow, since FRAME_LEN <= 248.
  - `frame_cnt` is 8 bits.
  - The comparison is unsigned.

## Timing

- Reset values:
  - state IDLE
  - `out_data` 0x00, `out_valid` 0
  - `frame_done` 0
  - `popcount` 0
  - `decision` 0
  - `overflow` 0
- Reset overrides every other input in the same cycle.
- Latencies:
  - Bit accepted on edge N → byte visible on `out_valid`/`out_data` after edge N (one-cycle latency from sample to output).
  - `frame_done` and `decision` update after the same edge that accepts the last bit. The final byte's `out_valid` rises together with `frame_done` (unless that byte overflows).
- Throughput:
  - One bit per cycle, sustained.
  - The host must accept each byte within 8 cycles of its assertion to avoid overflow.
- `out_data` must not change while `out_valid=1` and the byte is not yet accepted.

## Test plan

- Reset, idle bits, then a frame:
  - Stimulus: reset; `bit_valid=1` with random bits for 10 cycles in IDLE; then `frame_start` and the 16 bits 1,0,1,1,0,0,0,0, 1,1,1,1,1,1,1,1 with `out_ready=1`.
  - Expect: no output before `frame_start`; bytes 0x0D then 0xFF; `popcount=11`; `decision=1`; `frame_done` a single pulse coinciding with the second byte's `out_valid`.
- Threshold boundary (THRESH=8):
  - A frame with exactly 8 ones gives `decision=1`.
  - A frame with 7 ones gives `decision=0`.
- Backpressure and overflow:
  - Stimulus: `out_ready=0` for an entire 16-bit frame.
  - Expect: first byte held stable with `out_valid=1`; second byte dropped; `overflow=1`.
  - Then raise `out_ready`: first byte accepted, `out_valid` falls.
- Accept and reload in the same cycle:
  - Raise `out_ready` exactly on the edge where the second byte completes.
  - Expect: both bytes delivered, `out_valid` never drops, `overflow=0`.
- Mid-frame restart:
  - Stimulus: `frame_start` after 5 bits, with `bit_valid=1` in that cycle.
  - Expect: partial byte discarded, `popcount=0`, that bit ignored; the next 16 bits form a full frame.
- Reset mid-frame with a pending byte:
  - Expect: all outputs return to their reset values on the next edge.
  - Expect: no `frame_done` until a new `frame_start` and 16 bits.
